// File: rtl/apb_bus_arbiter_if.sv
// apb_bus_arbiter_if: requester handshakes plus APB master bus shared by the arbiter and its environment
interface apb_bus_arbiter_if;
  logic        req0_valid, req0_write, req0_ready, req0_done, req0_err;
  logic [31:0] req0_addr, req0_wdata, req0_rdata;
  logic        req1_valid, req1_write, req1_ready, req1_done, req1_err;
  logic [31:0] req1_addr, req1_wdata, req1_rdata;
  logic [31:0] PADDR, PWDATA, PRDATA1, PRDATA2;
  logic        PWRITE, PENABLE, PSEL1, PSEL2, PREADY1, PREADY2;
  modport master (
    input  req0_valid, req0_write, req0_addr, req0_wdata,
    input  req1_valid, req1_write, req1_addr, req1_wdata,
    input  PRDATA1, PRDATA2, PREADY1, PREADY2,
    output req0_ready, req0_done, req0_err, req0_rdata,
    output req1_ready, req1_done, req1_err, req1_rdata,
    output PADDR, PWDATA, PWRITE, PENABLE, PSEL1, PSEL2
  );
  modport slave (
    output req0_valid, req0_write, req0_addr, req0_wdata,
    output req1_valid, req1_write, req1_addr, req1_wdata,
    output PRDATA1, PRDATA2, PREADY1, PREADY2,
    input  req0_ready, req0_done, req0_err, req0_rdata,
    input  req1_ready, req1_done, req1_err, req1_rdata,
    input  PADDR, PWDATA, PWRITE, PENABLE, PSEL1, PSEL2
  );
endinterface

// File: rtl/apb_bus_arbiter.sv
// apb_bus_arbiter: round-robin two-requester APB master with address decode and wait-state timeout
module apb_bus_arbiter #(
  parameter int TIMEOUT = 16
) (
  input logic               PCLK,
  input logic               PRESETn,
  apb_bus_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t      state_q, state_d;
  logic        last_q, last_d, gnt_q, gnt_d;
  logic        pwrite_q, pwrite_d, penable_q, penable_d, psel1_q, psel1_d, psel2_q, psel2_d;
  logic [7:0]  wait_q, wait_d;
  logic [31:0] paddr_q, paddr_d, pwdata_q, pwdata_d;
  logic [1:0]  done_q, done_d, err_q, err_d;
  logic [1:0][31:0] rdata_q, rdata_d;
  logic        grant, gnt, sel_ready;
  logic [31:0] sel_rdata, req_addr;
  assign gnt       = (bus.req0_valid && bus.req1_valid) ? ~last_q : bus.req1_valid;
  assign grant     = PRESETn && state_q == IDLE && (bus.req0_valid || bus.req1_valid);
  assign req_addr  = gnt ? bus.req1_addr : bus.req0_addr;
  assign sel_ready = paddr_q[8] ? bus.PREADY2 : bus.PREADY1;
  assign sel_rdata = paddr_q[8] ? bus.PRDATA2 : bus.PRDATA1;
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    wait_d    = wait_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pwrite_d  = pwrite_q;
    penable_d = penable_q;
    psel1_d   = psel1_q;
    psel2_d   = psel2_q;
    rdata_d   = rdata_q;
    done_d    = '0;
    err_d     = '0;
    case (state_q)
      IDLE: if (grant) begin
        gnt_d    = gnt;
        paddr_d  = req_addr;
        pwdata_d = gnt ? bus.req1_wdata : bus.req0_wdata;
        pwrite_d = gnt ? bus.req1_write : bus.req0_write;
        psel1_d  = ~req_addr[8];
        psel2_d  = req_addr[8];
        wait_d   = '0;
        state_d  = SETUP;
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: if (sel_ready || wait_q == 8'(TIMEOUT)) begin
        // a PREADY arriving on the timeout cycle still counts as success
        done_d[gnt_q] = 1'b1;
        err_d[gnt_q]  = ~sel_ready;
        if (!pwrite_q) rdata_d[gnt_q] = sel_ready ? sel_rdata : '0;
        last_d    = gnt_q;
        psel1_d   = 1'b0;
        psel2_d   = 1'b0;
        penable_d = 1'b0;
        state_d   = IDLE;
      end else wait_d = wait_q + 8'd1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      gnt_q     <= 1'b0;
      wait_q    <= '0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      penable_q <= 1'b0;
      psel1_q   <= 1'b0;
      psel2_q   <= 1'b0;
      rdata_q   <= '0;
      done_q    <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      wait_q    <= wait_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pwrite_q  <= pwrite_d;
      penable_q <= penable_d;
      psel1_q   <= psel1_d;
      psel2_q   <= psel2_d;
      rdata_q   <= rdata_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end
  assign bus.req0_ready = grant && !gnt;
  assign bus.req1_ready = grant && gnt;
  assign bus.req0_done  = done_q[0];
  assign bus.req1_done  = done_q[1];
  assign bus.req0_err   = err_q[0];
  assign bus.req1_err   = err_q[1];
  assign bus.req0_rdata = rdata_q[0];
  assign bus.req1_rdata = rdata_q[1];
  assign bus.PADDR      = paddr_q;
  assign bus.PWDATA     = pwdata_q;
  assign bus.PWRITE     = pwrite_q;
  assign bus.PENABLE    = penable_q;
  assign bus.PSEL1      = psel1_q;
  assign bus.PSEL2      = psel2_q;
endmodule

// File: tb/tb_apb_bus_arbiter.sv
// tb_apb_bus_arbiter: per-cycle vector table plus hand sequences for async reset mid-transfer
module tb_apb_bus_arbiter;
  logic PCLK = 1'b0;
  logic PRESETn = 1'b0;
  always #5 PCLK = ~PCLK;
  apb_bus_arbiter_if bus();
  apb_bus_arbiter #(.TIMEOUT(4)) dut (.PCLK(PCLK), .PRESETn(PRESETn), .bus(bus));
  typedef struct {
    logic [1:0]  v, w, rdy;
    logic [31:0] a0, a1, wd, prd;
    logic [1:0]  er, es;
    logic        en;
    logic [1:0]  ed, eerr;
    logic        epw;
    logic [31:0] epa, erd0, erd1;
  } vec_t;
  localparam logic [31:0] WD = 32'h0000_00A5, DB = 32'hDEAD_BEEF, RD = 32'h1234_5678;
  int n_vec = 0;
  int n_bad = 0;
  function automatic vec_t mk(logic [1:0] v, w, logic [31:0] a0, a1, wd, logic [1:0] rdy, logic [31:0] prd,
                              logic [1:0] er, es, logic en, logic [1:0] ed, eerr, logic epw,
                              logic [31:0] epa, erd0, erd1);
    vec_t t;
    t.v = v; t.w = w; t.a0 = a0; t.a1 = a1; t.wd = wd; t.rdy = rdy; t.prd = prd;
    t.er = er; t.es = es; t.en = en; t.ed = ed; t.eerr = eerr; t.epw = epw;
    t.epa = epa; t.erd0 = erd0; t.erd1 = erd1;
    return t;
  endfunction
  function automatic logic [105:0] obs();
    return {bus.req1_ready, bus.req0_ready, bus.PSEL2, bus.PSEL1, bus.PENABLE, bus.req1_done, bus.req0_done,
            bus.req1_err, bus.req0_err, bus.PWRITE, bus.PADDR, bus.req0_rdata, bus.req1_rdata};
  endfunction
  function automatic logic [105:0] expv(vec_t t);
    return {t.er, t.es, t.en, t.ed, t.eerr, t.epw, t.epa, t.erd0, t.erd1};
  endfunction
  task automatic chk(input string nm, input logic [105:0] got, input logic [105:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  task automatic drive(input vec_t t);
    bus.req0_valid = t.v[0];  bus.req1_valid = t.v[1];
    bus.req0_write = t.w[0];  bus.req1_write = t.w[1];
    bus.req0_addr  = t.a0;    bus.req1_addr  = t.a1;
    bus.req0_wdata = t.wd;    bus.req1_wdata = t.wd;
    bus.PREADY1    = t.rdy[0]; bus.PREADY2   = t.rdy[1];
    bus.PRDATA1    = t.prd;   bus.PRDATA2    = t.prd;
  endtask
  task automatic step();
    @(posedge PCLK);
    #1;
  endtask
  initial begin
    vec_t tbl[$];
    vec_t z;
    // zero-wait write from req0 to UART
    tbl.push_back(mk(2'b01, 2'b01, 32'h4, 32'h0, WD, 2'b00, 32'h0, 2'b01, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0));
    tbl.push_back(mk(2'b00, 2'b01, 32'h4, 32'h0, WD, 2'b01, 32'h0, 2'b00, 2'b01, 1'b0, 2'b00, 2'b00, 1'b1, 32'h4, 32'h0, 32'h0));
    tbl.push_back(mk(2'b00, 2'b01, 32'h4, 32'h0, WD, 2'b01, 32'h0, 2'b00, 2'b01, 1'b1, 2'b00, 2'b00, 1'b1, 32'h4, 32'h0, 32'h0));
    tbl.push_back(mk(2'b00, 2'b01, 32'h4, 32'h0, WD, 2'b01, 32'h0, 2'b00, 2'b00, 1'b0, 2'b01, 2'b00, 1'b1, 32'h4, 32'h0, 32'h0));
    // req1 read from GPIO with two wait states; PREADY1 high must be ignored
    tbl.push_back(mk(2'b10, 2'b00, 32'h4, 32'h100, WD, 2'b00, 32'h0, 2'b10, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 32'h4, 32'h0, 32'h0));
    tbl.push_back(mk(2'b00, 2'b00, 32'h4, 32'h100, WD, 2'b00, 32'h0, 2'b00, 2'b10, 1'b0, 2'b00, 2'b00, 1'b0, 32'h100, 32'h0, 32'h0));
    tbl.push_back(mk(2'b00, 2'b00, 32'h4, 32'h100, WD, 2'b01, 32'h0, 2'b00, 2'b10, 1'b1, 2'b00, 2'b00, 1'b0, 32'h100, 32'h0, 32'h0));
    tbl.push_back(mk(2'b00, 2'b00, 32'h4, 32'h100, WD, 2'b01, 32'h0, 2'b00, 2'b10, 1'b1, 2'b00, 2'b00, 1'b0, 32'h100, 32'h0, 32'h0));
    tbl.push_back(mk(2'b00, 2'b00, 32'h4, 32'h100, WD, 2'b10, DB,    2'b00, 2'b10, 1'b1, 2'b00, 2'b00, 1'b0, 32'h100, 32'h0, 32'h0));
    tbl.push_back(mk(2'b00, 2'b00, 32'h4, 32'h100, WD, 2'b00, 32'h0, 2'b00, 2'b00, 1'b0, 2'b10, 2'b00, 1'b0, 32'h100, 32'h0, DB));
    // both requesters continuously valid: grants alternate 0,1,0,1
    tbl.push_back(mk(2'b11, 2'b11, 32'h10, 32'h104, WD, 2'b11, 32'h0, 2'b01, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 32'h100, 32'h0, DB));
    tbl.push_back(mk(2'b11, 2'b11, 32'h10, 32'h104, WD, 2'b11, 32'h0, 2'b00, 2'b01, 1'b0, 2'b00, 2'b00, 1'b1, 32'h10, 32'h0, DB));
    tbl.push_back(mk(2'b11, 2'b11, 32'h10, 32'h104, WD, 2'b11, 32'h0, 2'b00, 2'b01, 1'b1, 2'b00, 2'b00, 1'b1, 32'h10, 32'h0, DB));
    tbl.push_back(mk(2'b11, 2'b11, 32'h10, 32'h104, WD, 2'b11, 32'h0, 2'b10, 2'b00, 1'b0, 2'b01, 2'b00, 1'b1, 32'h10, 32'h0, DB));
    tbl.push_back(mk(2'b11, 2'b11, 32'h10, 32'h104, WD, 2'b11, 32'h0, 2'b00, 2'b10, 1'b0, 2'b00, 2'b00, 1'b1, 32'h104, 32'h0, DB));
    tbl.push_back(mk(2'b11, 2'b11, 32'h10, 32'h104, WD, 2'b11, 32'h0, 2'b00, 2'b10, 1'b1, 2'b00, 2'b00, 1'b1, 32'h104, 32'h0, DB));
    tbl.push_back(mk(2'b11, 2'b11, 32'h10, 32'h104, WD, 2'b11, 32'h0, 2'b01, 2'b00, 1'b0, 2'b10, 2'b00, 1'b1, 32'h104, 32'h0, DB));
    tbl.push_back(mk(2'b11, 2'b11, 32'h10, 32'h104, WD, 2'b11, 32'h0, 2'b00, 2'b01, 1'b0, 2'b00, 2'b00, 1'b1, 32'h10, 32'h0, DB));
    tbl.push_back(mk(2'b11, 2'b11, 32'h10, 32'h104, WD, 2'b11, 32'h0, 2'b00, 2'b01, 1'b1, 2'b00, 2'b00, 1'b1, 32'h10, 32'h0, DB));
    tbl.push_back(mk(2'b11, 2'b11, 32'h10, 32'h104, WD, 2'b11, 32'h0, 2'b10, 2'b00, 1'b0, 2'b01, 2'b00, 1'b1, 32'h10, 32'h0, DB));
    tbl.push_back(mk(2'b00, 2'b11, 32'h10, 32'h104, WD, 2'b11, 32'h0, 2'b00, 2'b10, 1'b0, 2'b00, 2'b00, 1'b1, 32'h104, 32'h0, DB));
    tbl.push_back(mk(2'b00, 2'b11, 32'h10, 32'h104, WD, 2'b11, 32'h0, 2'b00, 2'b10, 1'b1, 2'b00, 2'b00, 1'b1, 32'h104, 32'h0, DB));
    tbl.push_back(mk(2'b00, 2'b11, 32'h10, 32'h104, WD, 2'b11, 32'h0, 2'b00, 2'b00, 1'b0, 2'b10, 2'b00, 1'b1, 32'h104, 32'h0, DB));
    // req0 read succeeds, then a read times out and clears rdata
    tbl.push_back(mk(2'b01, 2'b00, 32'hC, 32'h104, WD, 2'b01, RD, 2'b01, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 32'h104, 32'h0, DB));
    tbl.push_back(mk(2'b00, 2'b00, 32'hC, 32'h104, WD, 2'b01, RD, 2'b00, 2'b01, 1'b0, 2'b00, 2'b00, 1'b0, 32'hC, 32'h0, DB));
    tbl.push_back(mk(2'b00, 2'b00, 32'hC, 32'h104, WD, 2'b01, RD, 2'b00, 2'b01, 1'b1, 2'b00, 2'b00, 1'b0, 32'hC, 32'h0, DB));
    tbl.push_back(mk(2'b00, 2'b00, 32'hC, 32'h104, WD, 2'b00, RD, 2'b00, 2'b00, 1'b0, 2'b01, 2'b00, 1'b0, 32'hC, RD, DB));
    tbl.push_back(mk(2'b01, 2'b00, 32'h8, 32'h104, WD, 2'b10, RD, 2'b01, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 32'hC, RD, DB));
    tbl.push_back(mk(2'b00, 2'b00, 32'h8, 32'h104, WD, 2'b10, RD, 2'b00, 2'b01, 1'b0, 2'b00, 2'b00, 1'b0, 32'h8, RD, DB));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(2'b00, 2'b00, 32'h8, 32'h104, WD, 2'b10, RD, 2'b00, 2'b01, 1'b1, 2'b00, 2'b00, 1'b0, 32'h8, RD, DB));
    tbl.push_back(mk(2'b00, 2'b00, 32'h8, 32'h104, WD, 2'b10, RD, 2'b00, 2'b00, 1'b0, 2'b01, 2'b01, 1'b0, 32'h8, 32'h0, DB));
    tbl.push_back(mk(2'b00, 2'b00, 32'h8, 32'h104, WD, 2'b00, RD, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 32'h8, 32'h0, DB));
    // reset: ready stays low even with both requesters valid
    z = mk(2'b11, 2'b11, 32'h104, 32'h104, WD, 2'b11, RD, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0);
    drive(z);
    #12;
    chk("reset", obs(), '0);
    chk("reset_pwdata", 106'(bus.PWDATA), '0);
    z.v = 2'b00;
    drive(z);
    @(negedge PCLK);
    PRESETn = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      step();
      drive(tbl[i]);
      @(negedge PCLK);
      chk($sformatf("vec%0d", i), obs(), expv(tbl[i]));
    end
    // req1 write to GPIO stalls, then reset hits during the wait states
    step();
    z = mk(2'b10, 2'b10, 32'h0, 32'h104, 32'h5A5A_1234, 2'b00, RD, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0);
    drive(z);
    @(negedge PCLK);
    chk("rst_seq_grant", 106'({bus.req1_ready, bus.req0_ready}), 106'(2'b10));
    step();
    z.v = 2'b00;
    drive(z);
    @(negedge PCLK);
    chk("rst_seq_setup", 106'({bus.PSEL2, bus.PSEL1, bus.PENABLE, bus.PWRITE, bus.PWDATA}), {70'h0, 4'b1001, 32'h5A5A_1234});
    step();
    step();
    @(negedge PCLK);
    chk("rst_seq_wait", 106'({bus.PSEL2, bus.PENABLE, bus.req1_done}), 106'(3'b110));
    PRESETn = 1'b0;
    #1;
    chk("async_reset", obs(), '0);
    chk("async_reset_pwdata", 106'(bus.PWDATA), '0);
    step();
    step();
    chk("reset_no_done", obs(), '0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    // fresh zero-wait read from req0 after release
    step();
    z = mk(2'b01, 2'b00, 32'h20, 32'h0, 32'h0, 2'b01, 32'hCAFE_F00D, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0);
    drive(z);
    @(negedge PCLK);
    chk("post_reset_grant", 106'({bus.req1_ready, bus.req0_ready}), 106'(2'b01));
    step();
    z.v = 2'b00;
    drive(z);
    step();
    step();
    @(negedge PCLK);
    chk("post_reset_done", 106'({bus.req1_done, bus.req0_done, bus.req0_err, bus.req0_rdata, bus.req1_rdata}),
        106'({3'b010, 32'hCAFE_F00D, 32'h0}));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
